// File: rtl/seq_pkg.sv
// Shared definitions for the fetch/execute step sequencer: microword field
// positions, bus-source encodings, fetch step numbers and the strobe bundle.
package seq_pkg;

    localparam int UW_RT     = 15;
    localparam int UW_INC    = 14;
    localparam int UW_JMP    = 13;
    localparam int UW_JZ     = 12;
    localparam int UW_JNZ    = 11;
    localparam int UW_HLT    = 10;
    localparam int UW_SRC_HI = 9;
    localparam int UW_SRC_LO = 7;
    localparam int UW_EXT_HI = 6;
    localparam int UW_EXT_LO = 0;

    typedef enum logic [2:0] {
        SRC_NONE = 3'd0,
        SRC_PC   = 3'd1,
        SRC_MEM  = 3'd2,
        SRC_EXT  = 3'd3
    } src_e;

    localparam int T_FETCH0 = 0;
    localparam int T_FETCH1 = 1;

    typedef struct packed {
        logic       pc_en_bar;
        logic       pc_load_bar;
        logic       pc_inc;
        logic       mar_load;
        logic       mem_en;
        logic       ir_load;
        logic       ext_en;
        logic [6:0] ext_ctl;
    } strobes_t;

    // Sources 4-7 have no driver behind them.
    function automatic logic src_is_reserved(input logic [2:0] src);
        return src[2];
    endfunction

endpackage

// File: rtl/useq_decode.sv
// Combinational step decoder: turns the current T-state and microword into
// datapath strobes, plus illegal/halt/end-of-instruction indications.
module useq_decode
    import seq_pkg::*;
#(
    parameter int TW = 3
) (
    input  logic [TW-1:0] i_tstate,
    input  logic [15:0]   i_uword,
    input  logic          i_flag_z,
    input  logic          i_wait_req,
    input  logic          i_halted,
    input  logic          i_reset,
    output strobes_t      o_strobes,
    output logic          o_illegal,
    output logic          o_halt,
    output logic          o_rt
);

    logic [2:0] w_src;
    logic       w_take;
    logic       w_bad;

    assign w_src  = i_uword[UW_SRC_HI:UW_SRC_LO];
    assign w_take = i_uword[UW_JMP] | (i_uword[UW_JZ] & i_flag_z) | (i_uword[UW_JNZ] & ~i_flag_z);
    // A taken load from the PC's own bus value is as meaningless as a reserved source.
    assign w_bad  = src_is_reserved(w_src) | (w_take & (w_src == SRC_PC));

    always_comb begin
        o_strobes             = '0;
        o_strobes.pc_en_bar   = 1'b1;
        o_strobes.pc_load_bar = 1'b1;
        o_illegal             = 1'b0;
        o_halt                = 1'b0;
        o_rt                  = 1'b0;

        if (!(i_reset || i_halted)) begin
            if (i_tstate == TW'(T_FETCH0)) begin
                o_strobes.pc_en_bar = 1'b0;
                o_strobes.mar_load  = ~i_wait_req;
            end else if (i_tstate == TW'(T_FETCH1)) begin
                o_strobes.mem_en  = 1'b1;
                o_strobes.ir_load = ~i_wait_req;
                o_strobes.pc_inc  = ~i_wait_req;
            end else begin
                o_illegal         = w_bad;
                o_strobes.ext_ctl = i_uword[UW_EXT_HI:UW_EXT_LO];
                if (!w_bad) begin
                    case (w_src)
                        SRC_PC:  o_strobes.pc_en_bar = 1'b0;
                        SRC_MEM: o_strobes.mem_en    = 1'b1;
                        SRC_EXT: o_strobes.ext_en    = 1'b1;
                        default: ;
                    endcase
                end
                // Edge-effective strobes fire only on the cycle the stall lifts.
                if (!i_wait_req) begin
                    if (w_take && !w_bad) begin
                        o_strobes.pc_load_bar = 1'b0;
                    end else begin
                        o_strobes.pc_inc = i_uword[UW_INC];
                    end
                    o_halt = i_uword[UW_HLT];
                    o_rt   = i_uword[UW_RT];
                end
            end
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// T-state sequencer for the CPU control path: owns the step counter, halt
// state and sticky microcode error, and exposes the decoded strobes.
module fetch_sequencer
    import seq_pkg::*;
#(
    parameter int NSTEPS = 8,
    parameter int TW     = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [7:0]      opcode,
    input  logic [15:0]     uword,
    input  logic            flag_z,
    input  logic            wait_req,
    input  logic            resume,
    output logic [8+TW-1:0] uaddr,
    output logic [TW-1:0]   tstate,
    output logic            pc_en_bar,
    output logic            pc_load_bar,
    output logic            pc_inc,
    output logic            mar_load,
    output logic            mem_en,
    output logic            ir_load,
    output logic            ext_en,
    output logic [6:0]      ext_ctl,
    output logic            halted,
    output logic            ucode_err
);

    logic [TW-1:0] r_tstate;
    logic          r_halted;
    logic          r_ucode_err;

    strobes_t      w_strobes;
    logic          w_illegal;
    logic          w_halt;
    logic          w_rt;

    useq_decode #(.TW(TW)) u_decode (
        .i_tstate   (r_tstate),
        .i_uword    (uword),
        .i_flag_z   (flag_z),
        .i_wait_req (wait_req),
        .i_halted   (r_halted),
        .i_reset    (reset),
        .o_strobes  (w_strobes),
        .o_illegal  (w_illegal),
        .o_halt     (w_halt),
        .o_rt       (w_rt)
    );

    // Halt parks the counter at T0 so resume restarts with a clean fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tstate    <= '0;
            r_halted    <= 1'b0;
            r_ucode_err <= 1'b0;
        end else begin
            if (w_illegal) begin
                r_ucode_err <= 1'b1;
            end
            if (r_halted) begin
                if (resume) begin
                    r_halted <= 1'b0;
                end
            end else if (!wait_req) begin
                if (w_halt) begin
                    r_halted <= 1'b1;
                    r_tstate <= '0;
                end else if (w_rt || r_tstate == TW'(NSTEPS - 1)) begin
                    r_tstate <= '0;
                end else begin
                    r_tstate <= r_tstate + 1'b1;
                end
            end
        end
    end

    assign uaddr       = {opcode, r_tstate};
    assign tstate      = r_tstate;
    assign halted      = r_halted;
    assign ucode_err   = r_ucode_err;
    assign pc_en_bar   = w_strobes.pc_en_bar;
    assign pc_load_bar = w_strobes.pc_load_bar;
    assign pc_inc      = w_strobes.pc_inc;
    assign mar_load    = w_strobes.mar_load;
    assign mem_en      = w_strobes.mem_en;
    assign ir_load     = w_strobes.ir_load;
    assign ext_en      = w_strobes.ext_en;
    assign ext_ctl     = w_strobes.ext_ctl;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed literal checks followed by random
// stimulus, all compared every cycle against a step-level behavioural model.
module tb_fetch_sequencer;

    localparam int NSTEPS = 8;
    localparam int TW     = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [7:0]      opcode;
    logic [15:0]     uword;
    logic            flag_z;
    logic            wait_req;
    logic            resume;
    logic [8+TW-1:0] uaddr;
    logic [TW-1:0]   tstate;
    logic            pc_en_bar, pc_load_bar, pc_inc, mar_load, mem_en, ir_load, ext_en;
    logic [6:0]      ext_ctl;
    logic            halted, ucode_err;

    int nVectors     = 0;
    int nMiscompares = 0;

    int mStep   = 0;
    bit mHalted = 1'b0;
    bit mErr    = 1'b0;

    typedef struct packed {
        logic       pcEnBar, pcLoadBar, pcInc, marLoad, memEn, irLoad, extEn;
        logic [6:0] extCtl;
    } expect_t;

    fetch_sequencer #(.NSTEPS(NSTEPS), .TW(TW)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .uword(uword), .flag_z(flag_z),
        .wait_req(wait_req), .resume(resume), .uaddr(uaddr), .tstate(tstate),
        .pc_en_bar(pc_en_bar), .pc_load_bar(pc_load_bar), .pc_inc(pc_inc),
        .mar_load(mar_load), .mem_en(mem_en), .ir_load(ir_load), .ext_en(ext_en),
        .ext_ctl(ext_ctl), .halted(halted), .ucode_err(ucode_err)
    );

    always #5 clk = ~clk;

    function automatic bit loadTaken(input logic [15:0] uw, input bit z);
        return uw[13] || (uw[12] && z) || (uw[11] && !z);
    endfunction

    function automatic bit badWord(input logic [15:0] uw, input bit z);
        int src;
        src = int'(uw[9:7]);
        return (src > 3) || (loadTaken(uw, z) && src == 1);
    endfunction

    function automatic expect_t expectStrobes(input int step, input bit hlt, input bit rst,
                                              input logic [15:0] uw, input bit z, input bit wr);
        expect_t s;
        s = '0;
        s.pcEnBar   = 1'b1;
        s.pcLoadBar = 1'b1;
        if (rst || hlt) return s;
        if (step == 0) begin
            s.pcEnBar = 1'b0;
            s.marLoad = !wr;
        end else if (step == 1) begin
            s.memEn  = 1'b1;
            s.irLoad = !wr;
            s.pcInc  = !wr;
        end else begin
            s.extCtl = uw[6:0];
            if (!badWord(uw, z)) begin
                if (uw[9:7] == 3'd1) s.pcEnBar = 1'b0;
                if (uw[9:7] == 3'd2) s.memEn = 1'b1;
                if (uw[9:7] == 3'd3) s.extEn = 1'b1;
            end
            if (!wr) begin
                if (loadTaken(uw, z) && !badWord(uw, z)) s.pcLoadBar = 1'b0;
                else s.pcInc = uw[14];
            end
        end
        return s;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit r, input logic [15:0] uw, input bit wr, input bit z, input bit res);
        @(posedge clk);
        #1;
        reset    = r;
        uword    = uw;
        wait_req = wr;
        flag_z   = z;
        resume   = res;
    endtask

    task automatic advanceTo(input int target);
        int n;
        n = 0;
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        while (mStep != target && n < 40) begin
            applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
            n++;
        end
        checkOutput("advance_step", 32'(mStep), 32'(target));
    endtask

    function automatic logic [6:0] strobeVec();
        return {pc_en_bar, pc_load_bar, pc_inc, mar_load, mem_en, ir_load, ext_en};
    endfunction

    // Reference model: one instruction step per unstalled cycle.
    always @(posedge clk) begin
        if (reset) begin
            mStep   <= 0;
            mHalted <= 1'b0;
            mErr    <= 1'b0;
        end else begin
            if (!mHalted && mStep >= 2 && badWord(uword, flag_z)) mErr <= 1'b1;
            if (mHalted) begin
                if (resume) mHalted <= 1'b0;
            end else if (!wait_req) begin
                if (mStep >= 2 && uword[10]) begin
                    mHalted <= 1'b1;
                    mStep   <= 0;
                end else if ((mStep >= 2 && uword[15]) || mStep == NSTEPS - 1) begin
                    mStep <= 0;
                end else begin
                    mStep <= mStep + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        expect_t e;
        e = expectStrobes(mStep, mHalted, reset, uword, flag_z, wait_req);
        checkOutput("tstate",      32'(tstate),      32'(mStep));
        checkOutput("uaddr",       32'(uaddr),       32'(int'(opcode) * NSTEPS + mStep));
        checkOutput("halted",      32'(halted),      32'(mHalted));
        checkOutput("ucode_err",   32'(ucode_err),   32'(mErr));
        checkOutput("pc_en_bar",   32'(pc_en_bar),   32'(e.pcEnBar));
        checkOutput("pc_load_bar", 32'(pc_load_bar), 32'(e.pcLoadBar));
        checkOutput("pc_inc",      32'(pc_inc),      32'(e.pcInc));
        checkOutput("mar_load",    32'(mar_load),    32'(e.marLoad));
        checkOutput("mem_en",      32'(mem_en),      32'(e.memEn));
        checkOutput("ir_load",     32'(ir_load),     32'(e.irLoad));
        checkOutput("ext_en",      32'(ext_en),      32'(e.extEn));
        checkOutput("ext_ctl",     32'(ext_ctl),     32'(e.extCtl));
        checkOutput("bus_drivers", 32'(int'(!pc_en_bar) + int'(mem_en) + int'(ext_en) <= 1), 32'd1);
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; opcode = 8'hA5; uword = '0; flag_z = 1'b0; wait_req = 1'b0; resume = 1'b0;

        applyStimulus(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0); #3;
        checkOutput("rst_tstate", 32'(tstate), 32'd0);
        checkOutput("rst_strobes", 32'(strobeVec()), 32'b1100000);

        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0); #3;
        checkOutput("t0_tstate", 32'(tstate), 32'd0);
        checkOutput("t0_strobes", 32'(strobeVec()), 32'b0101000);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0); #3;
        checkOutput("t1_strobes", 32'(strobeVec()), 32'b1110110);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0); #3;
        checkOutput("t3_uaddr", 32'(uaddr), 32'h52B);
        repeat (4) applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        #3 checkOutput("t7_tstate", 32'(tstate), 32'd7);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0); #3;
        checkOutput("wrap_tstate", 32'(tstate), 32'd0);

        advanceTo(2); uword = 16'h8000; #2;
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0); #3;
        checkOutput("rt_tstate", 32'(tstate), 32'd0);

        advanceTo(2); uword = 16'h6100; #2;
        checkOutput("jmp_inc_strobes", 32'(strobeVec()), 32'b1000100);

        advanceTo(2); uword = 16'h1180; flag_z = 1'b1; #2;
        checkOutput("jz_z1_strobes", 32'(strobeVec()), 32'b1000001);
        advanceTo(2); uword = 16'h1180; flag_z = 1'b0; #2;
        checkOutput("jz_z0_pc_load_bar", 32'(pc_load_bar), 32'd1);
        advanceTo(2); uword = 16'h0980; flag_z = 1'b0; #2;
        checkOutput("jnz_z0_pc_load_bar", 32'(pc_load_bar), 32'd0);
        advanceTo(2); uword = 16'h0980; flag_z = 1'b1; #2;
        checkOutput("jnz_z1_pc_load_bar", 32'(pc_load_bar), 32'd1);

        advanceTo(1); wait_req = 1'b1; #2;
        checkOutput("stall_strobes", 32'({tstate, strobeVec()}), 32'({3'd1, 7'b1100100}));
        repeat (2) begin
            applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0); #3;
            checkOutput("stall_strobes", 32'({tstate, strobeVec()}), 32'({3'd1, 7'b1100100}));
        end
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0); #3;
        checkOutput("release_strobes", 32'({tstate, strobeVec()}), 32'({3'd1, 7'b1110110}));
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0); #3;
        checkOutput("after_release", 32'({tstate, ir_load}), 32'({3'd2, 1'b0}));

        advanceTo(2); uword = 16'h2080; #2;
        checkOutput("illegal_pc_strobes", 32'(strobeVec()), 32'b1100000);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0); #3;
        checkOutput("ucode_err_set", 32'(ucode_err), 32'd1);
        advanceTo(2); #2;
        checkOutput("ucode_err_sticky", 32'(ucode_err), 32'd1);
        applyStimulus(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0); #3;
        checkOutput("ucode_err_cleared", 32'(ucode_err), 32'd0);
        advanceTo(2); uword = 16'h0280; #2;
        checkOutput("illegal_src5_strobes", 32'(strobeVec()), 32'b1100000);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0); #3;
        checkOutput("ucode_err_src5", 32'(ucode_err), 32'd1);
        applyStimulus(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);

        advanceTo(3); uword = 16'h0400; #2;
        checkOutput("pre_halt", 32'(halted), 32'd0);
        repeat (10) begin
            applyStimulus(1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0); #3;
            checkOutput("halted_idle", 32'({halted, tstate, strobeVec(), ext_ctl}),
                        32'({1'b1, 3'd0, 7'b1100000, 7'd0}));
        end
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1); #3;
        checkOutput("resume_cycle", 32'(halted), 32'd1);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0); #3;
        checkOutput("resumed_t0", 32'({halted, tstate, strobeVec()}), 32'({1'b0, 3'd0, 7'b0101000}));

        advanceTo(4);
        applyStimulus(1'b1, 16'h6180, 1'b0, 1'b0, 1'b0); #3;
        checkOutput("mid_reset_strobes", 32'({strobeVec(), ext_ctl}), 32'({7'b1100000, 7'd0}));
        applyStimulus(1'b0, 16'h6180, 1'b0, 1'b0, 1'b0); #3;
        checkOutput("post_reset_t0", 32'({tstate, strobeVec()}), 32'({3'd0, 7'b0101000}));

        // Random phase: sparse halts, illegal words and resets keep every path live.
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] uw;
            logic [2:0]  src;
            uw     = 16'($urandom);
            uw[15] = ($urandom_range(0, 3) == 0);
            uw[13] = ($urandom_range(0, 3) == 0);
            uw[12] = ($urandom_range(0, 3) == 0);
            uw[11] = ($urandom_range(0, 3) == 0);
            uw[10] = ($urandom_range(0, 15) == 0);
            src = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            if (src == 3'd1 && $urandom_range(0, 9) != 0) uw[13:11] = 3'b000;
            uw[9:7] = src;
            applyStimulus(($urandom_range(0, 99) == 0), uw, ($urandom_range(0, 4) == 0),
                          1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
            opcode = 8'($urandom);
        end

        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
